// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset level; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_client_rx.sv
// 8N1 UART receiver; byte ready ~9.5 bit times + 3 clocks after the start edge.
// Holds one byte until rx_ack; a byte arriving while one is pending is dropped and flagged.
module uart_client_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;

  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt, ferr_nxt, ovr_nxt;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  assign busy = (state != RxIdle);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    data_nxt  = rx_data;
    // Ack is applied first so a byte completing on the same edge sees an empty slot.
    valid_nxt = rx_valid & ~rx_ack;
    ferr_nxt  = frame_err & ~rx_ack;
    ovr_nxt   = overrun & ~rx_ack;
    case (state)
      RxIdle: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = RxStart;
      end
      RxStart: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          bit_nxt   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = RxStop;
        end
      end
      RxStop: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            ferr_nxt  = 1'b1;
            state_nxt = RxWaitHigh;
          end else begin
            state_nxt = RxIdle;
            if (valid_nxt) begin
              ovr_nxt = 1'b1;
            end else begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
            end
          end
        end
      end
      // A held-low line (break) must go high before another start is considered.
      RxWaitHigh: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = RxIdle;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = RxIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RxIdle;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_client_rx.sv
// Randomized and directed bench for uart_client_rx against a frame-level reference model.
module tb_uart_client_rx;
  import uart_pkg::*;

  localparam int CPB = CLKS_PER_BIT_DEF;
  // Posedge index (from the start-bit negedge) on which the stop bit is sampled.
  localparam int STOP_EDGE = 2 + CPB / 2 + 9 * CPB;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       rx_in  = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  always #5 clock = ~clock;

  uart_client_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference behaviour: what a finished frame does to the consumer-visible state.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_data  = b;
      m_valid = 1'b1;
    end
  endtask

  task automatic model_ack();
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_reset();
    model_ack();
    m_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = frame[i];
      clks(CPB);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input logic stop);
    send_frame(b, stop);
    model_frame(b, stop);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    clks(1);
    rx_ack = 1'b0;
    model_ack();
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.data", tag), {24'h0, rx_data}, {24'h0, m_data});
    check($sformatf("%s.valid", tag), {31'h0, rx_valid}, {31'h0, m_valid});
    check($sformatf("%s.ferr", tag), {31'h0, frame_err}, {31'h0, m_ferr});
    check($sformatf("%s.ovr", tag), {31'h0, overrun}, {31'h0, m_ovr});
    check($sformatf("%s.busy", tag), {31'h0, busy}, 32'h0);
  endtask

  initial begin
    repeat (100000) @(posedge clock);
    $display("FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] b;
    logic stop;

    clks(3);
    check_all("reset");
    reset = 1'b1;
    clks(2);
    check_all("idle");

    xfer(8'h4F, 1'b1);
    clks(CPB);
    check_all("byte_4f");
    do_ack();
    check_all("ack_4f");

    xfer(8'h55, 1'b1);
    clks(CPB);
    xfer(8'hAA, 1'b1);
    clks(CPB);
    check_all("overrun");
    do_ack();
    clks(1);
    check_all("overrun_ack");

    xfer(8'h00, 1'b0);
    clks(40);
    check("break.busy_low", {31'h0, busy}, 32'h1);
    check("break.ferr", {31'h0, frame_err}, 32'h1);
    check("break.valid", {31'h0, rx_valid}, 32'h0);
    rx_in = 1'b1;
    n = 0;
    while (busy && n < 6) begin
      clks(1);
      n++;
    end
    check("break.busy_fall", {31'h0, busy}, 32'h0);
    clks(2 * CPB);
    check_all("break_after");
    do_ack();

    rx_in = 1'b0;
    clks(3);
    check("glitch.busy_seen", {31'h0, busy}, 32'h1);
    rx_in = 1'b1;
    clks(2 * CPB);
    check_all("glitch");

    xfer(8'h7E, 1'b1);
    clks(CPB);
    fork
      send_frame(8'h31, 1'b1);
      begin
        clks(STOP_EDGE);
        rx_ack = 1'b1;
        clks(1);
        rx_ack = 1'b0;
      end
    join
    model_ack();
    model_frame(8'h31, 1'b1);
    clks(CPB);
    check_all("ack_coincide");
    do_ack();

    fork
      send_frame(8'hC3, 1'b1);
      begin
        clks(2 + CPB / 2 + 4 * CPB + CPB / 2);
        reset = 1'b0;
        clks(2 * CPB);
        reset = 1'b1;
      end
    join
    model_reset();
    clks(CPB);
    check_all("reset_abandon");
    xfer(8'h12, 1'b1);
    clks(CPB);
    check_all("after_reset");

    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) do_ack();
      xfer(b, stop);
      rx_in = 1'b1;
      clks(CPB + $urandom_range(0, CPB));
      check_all($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_client_rx.md
UART_CLIENT_RX -- requirements
Module: uart_client_rx

Interface
REQ-001 Parameter CLKS_PER_BIT SHALL be declared as: CLKS_PER_BIT, default 16, system clocks per serial bit (even, >= 4).
REQ-002 Port clock SHALL be declared as: clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be declared as: reset  input  1  asynchronous, active-low reset.
REQ-004 Port rx_in SHALL be declared as: rx_in  input  1  serial line from the UART tx_out; idle high; 8N1, LSB first.
REQ-005 Port rx_ack SHALL be declared as: rx_ack  input  1  active-high; consumer has taken rx_data and status.
REQ-006 Port rx_data SHALL be declared as: rx_data  output  8  last accepted byte.
REQ-007 Port rx_valid SHALL be declared as: rx_valid  output  1  rx_data holds an unacknowledged byte.
REQ-008 Port frame_err SHALL be declared as: frame_err  output  1  sticky; stop bit sampled low.
REQ-009 Port overrun SHALL be declared as: overrun  output  1  sticky; byte completed while rx_valid was set.
REQ-010 Port busy SHALL be declared as: busy  output  1  high whenever the FSM is not in RxIdle.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value (2-cycle latency).
REQ-012 States SHALL be RxIdle, RxStart, RxData, RxStop and RxWaitHigh.
REQ-013 RxIdle: synchronized rx low SHALL enter RxStart with the bit counter cleared.
REQ-014 RxStart: at count CLKS_PER_BIT/2-1, rx low SHALL enter RxData with counter and bit index cleared; rx high SHALL return to RxIdle as a false start, with no status change.
REQ-015 RxData: at count CLKS_PER_BIT-1, rx SHALL shift into the shift register at the MSB while shifting right (LSB first).
REQ-016 RxData: after bit index 7 is sampled, the FSM SHALL enter RxStop.
REQ-017 RxStop: at count CLKS_PER_BIT-1, stop bit high with rx_valid low SHALL load rx_data, set rx_valid and enter RxIdle.
REQ-018 RxStop: stop bit high with rx_valid high SHALL discard the byte, set overrun and enter RxIdle.
REQ-019 RxStop: stop bit low SHALL discard the byte, set frame_err and enter RxWaitHigh.
REQ-020 RxWaitHigh SHALL stay until synchronized rx is high, then enter RxIdle; a break condition SHALL never retrigger reception.
REQ-021 rx_ack high SHALL clear rx_valid, frame_err and overrun on the next edge; rx_data SHALL hold its value.
REQ-022 If rx_ack and a good stop bit coincide, ack SHALL be processed first: new byte loaded, rx_valid stays 1, overrun not set.
REQ-023 Bit counter width SHALL be $clog2(CLKS_PER_BIT); counter SHALL reset to 0 on every state transition; no wrap inside a bit.
REQ-024 End-of-byte latency SHALL be ~ (9.5 x CLKS_PER_BIT + 3) clocks from the start-bit falling edge; rx_valid asserts on the stop-bit mid-sample edge plus one.

Reset
REQ-025 reset low SHALL asynchronously force state RxIdle, counters 0, synchronizer flops 1, rx_data 8'h00, and rx_valid, frame_err, overrun, busy 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no status set; after release, reception SHALL resume only on a new falling edge.

Structure
REQ-027 Package uart_pkg SHALL hold the RxState enum and the default CLKS_PER_BIT constant, shared with the UART bus component and simulation top.
REQ-028 One sub-module, sync_2ff (parameterized reset value, async active-low reset), SHALL implement the synchronizer.
REQ-029 All other logic SHALL be a single comb next-state block plus one sequential block, consistent with the existing FSM coding style.

Verification
REQ-030 Bench SHALL cover: 8'h4F framed 0,1,1,1,1,0,0,1,0,1 at CLKS_PER_BIT=16 -> rx_data=8'h4F, rx_valid=1, frame_err=0, overrun=0.
REQ-031 Bench SHALL cover: 8'h55 sent, no ack, then 8'hAA sent -> rx_data stays 8'h55, overrun=1; after rx_ack, all flags 0 and rx_data=8'h55.
REQ-032 Bench SHALL cover: 8'h00 with stop bit low, line held low 40 clocks, then high -> frame_err=1, rx_valid=0, no second frame, busy falls after line high.
REQ-033 Bench SHALL cover: 3-clock low glitch on idle line -> FSM returns to RxIdle, no flags, rx_valid=0.
REQ-034 Bench SHALL cover: rx_ack pulsed on the exact edge the second byte 8'h31 completes -> rx_data=8'h31, rx_valid=1, overrun=0.
REQ-035 Bench SHALL cover: reset asserted during bit 4 of 8'hC3, released, then 8'h12 sent -> only 8'h12 reported, no frame_err.
